// File: rtl/router_pkg.sv
// Shared types and constants for the core-to-slave memory request router.
// Holds the default SoC address map, the router FSM state type and the request payload.
package router_pkg;

  // Payload widths of a buffered/issued request (match the router defaults).
  localparam int unsigned REQ_ADDR_W = 32;
  localparam int unsigned REQ_DATA_W = 32;
  localparam int unsigned REQ_STRB_W = REQ_DATA_W / 8;

  // Default address map; tops are exclusive.
  localparam logic [31:0] ROM_BASE   = 32'h0000_0000;
  localparam logic [31:0] ROM_TOP    = 32'h0000_0080;
  localparam logic [31:0] PRINT_BASE = 32'h0100_0000;
  localparam logic [31:0] PRINT_TOP  = 32'h0100_0004;
  localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
  localparam logic [31:0] CLINT_TOP  = 32'h0200_C000;
  localparam logic [31:0] BRAM_BASE  = 32'h8000_0000;
  localparam logic [31:0] BRAM_TOP   = 32'h9000_0000;

  // Region 0 sits in the LSBs.
  localparam logic [127:0] DEF_BASE_ADDR = {BRAM_BASE, CLINT_BASE, PRINT_BASE, ROM_BASE};
  localparam logic [127:0] DEF_TOP_ADDR  = {BRAM_TOP, CLINT_TOP, PRINT_TOP, ROM_TOP};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  typedef struct packed {
    logic                  instr;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
    logic [REQ_STRB_W-1:0] wstrb;
  } req_t;

endpackage

// File: rtl/region_decoder.sv
// Combinational address-region decoder.
// Ports: addr (request address) -> hit (any region matched),
//        sel_oh (one-hot winning region), sel (index of winning region).
// A region matches when base <= addr < top (unsigned); the lowest index wins on overlap.
module region_decoder #(
  parameter int unsigned                 NUM_SLV   = 4,
  parameter int unsigned                 ADDR_W    = 32,
  parameter int unsigned                 SEL_W     = 2,
  parameter logic [NUM_SLV*ADDR_W-1:0]   BASE_ADDR = '0,
  parameter logic [NUM_SLV*ADDR_W-1:0]   TOP_ADDR  = '0
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic               hit,
  output logic [NUM_SLV-1:0] sel_oh,
  output logic [SEL_W-1:0]   sel
);

  // Walk from the highest index down so the lowest matching region is the last writer.
  always_comb begin
    hit    = 1'b0;
    sel_oh = '0;
    sel    = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((addr >= BASE_ADDR[i*ADDR_W +: ADDR_W]) && (addr < TOP_ADDR[i*ADDR_W +: ADDR_W])) begin
        hit       = 1'b1;
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
        sel       = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/mem_region_router.sv
// Memory-request router between one core memory port and NUM_SLV slaves.
// Regions come from the BASE_ADDR/TOP_ADDR parameter arrays; unmapped requests get an
// error response. A one-entry buffer absorbs a request arriving while busy; a request
// that finds the buffer full is dropped and raises the sticky overflow flag.
// Ports:
//   clock, reset          - clock, synchronous active-high reset
//   m_valid/m_instr/m_addr/m_wdata/m_wstrb - core request (one-cycle strobe, wstrb 0 = read)
//   m_ready/m_rdata/m_error               - core response (one-cycle strobe)
//   s_valid[NUM_SLV]                      - per-slave request strobe
//   s_instr/s_addr/s_wdata/s_wstrb        - shared request payload, held between requests
//   s_ready[NUM_SLV]/s_rdata              - per-slave response strobe and read data
//   overflow                              - sticky dropped-request flag
// Optional: define ROUTER_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYC silent cycles.
module mem_region_router
  import router_pkg::*;
#(
  parameter int unsigned               NUM_SLV     = 4,
  parameter int unsigned               ADDR_W      = 32,
  parameter int unsigned               DATA_W      = 32,
  parameter logic [NUM_SLV*ADDR_W-1:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter logic [NUM_SLV*ADDR_W-1:0] TOP_ADDR    = DEF_TOP_ADDR,
  parameter int unsigned               TIMEOUT_CYC = 1024
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      m_valid,
  input  logic                      m_instr,
  input  logic [ADDR_W-1:0]         m_addr,
  input  logic [DATA_W-1:0]         m_wdata,
  input  logic [DATA_W/8-1:0]       m_wstrb,
  output logic                      m_ready,
  output logic [DATA_W-1:0]         m_rdata,
  output logic                      m_error,
  output logic [NUM_SLV-1:0]        s_valid,
  output logic                      s_instr,
  output logic [ADDR_W-1:0]         s_addr,
  output logic [DATA_W-1:0]         s_wdata,
  output logic [DATA_W/8-1:0]       s_wstrb,
  input  logic [NUM_SLV-1:0]        s_ready,
  input  logic [NUM_SLV*DATA_W-1:0] s_rdata,
  output logic                      overflow
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned SEL_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  state_t               state_q, state_d;
  req_t                 buf_q, buf_d;
  logic                 buf_full_q, buf_full_d;
  req_t                 issue_q, issue_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [NUM_SLV-1:0]   s_valid_d;
  logic                 m_ready_d;
  logic [DATA_W-1:0]    m_rdata_d;
  logic                 m_error_d;
  logic                 overflow_d;

  req_t                 in_req;
  req_t                 src_req;
  logic                 src_valid;
  logic                 dec_hit;
  logic [NUM_SLV-1:0]   dec_oh;
  logic [SEL_W-1:0]     dec_sel;
  logic                 sel_ready;
  logic [DATA_W-1:0]    sel_rdata;

  // Incoming core request packed into the shared payload format.
  always_comb begin
    in_req       = '0;
    in_req.instr = m_instr;
    in_req.addr  = REQ_ADDR_W'(m_addr);
    in_req.wdata = REQ_DATA_W'(m_wdata);
    in_req.wstrb = REQ_STRB_W'(m_wstrb);
  end

  // A buffered request always takes priority over a fresh one.
  assign src_valid = buf_full_q | m_valid;
  assign src_req   = buf_full_q ? buf_q : in_req;

  region_decoder #(
    .NUM_SLV   (NUM_SLV),
    .ADDR_W    (ADDR_W),
    .SEL_W     (SEL_W),
    .BASE_ADDR (BASE_ADDR),
    .TOP_ADDR  (TOP_ADDR)
  ) u_decoder (
    .addr   (ADDR_W'(src_req.addr)),
    .hit    (dec_hit),
    .sel_oh (dec_oh),
    .sel    (dec_sel)
  );

  // Only the slave that owns the outstanding request is listened to.
  assign sel_ready = s_ready[sel_q];
  assign sel_rdata = s_rdata[sel_q*DATA_W +: DATA_W];

`ifdef ROUTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  // Next-state, response and buffer logic.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    issue_d    = issue_q;
    sel_d      = sel_q;
    s_valid_d  = '0;
    m_ready_d  = 1'b0;
    m_rdata_d  = '0;
    m_error_d  = 1'b0;
    overflow_d = overflow;
`ifdef ROUTER_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (src_valid) begin
          buf_full_d = 1'b0;
          if (dec_hit) begin
            issue_d   = src_req;
            sel_d     = dec_sel;
            s_valid_d = dec_oh;
            state_d   = WAIT;
`ifdef ROUTER_TIMEOUT_EN
            cnt_d     = '0;
`endif
          end else begin
            state_d = ERR;
          end
        end
      end
      WAIT: begin
        if (sel_ready) begin
          m_ready_d = 1'b1;
          m_rdata_d = sel_rdata;
          state_d   = IDLE;
        end
`ifdef ROUTER_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          m_ready_d = 1'b1;
          m_error_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ERR: begin
        m_ready_d = 1'b1;
        m_error_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A request not consumed directly goes to the buffer; in IDLE with the buffer full
    // the entry is being issued this cycle, so its slot is free for the newcomer.
    if (m_valid && !((state_q == IDLE) && !buf_full_q)) begin
      if (!buf_full_q || (state_q == IDLE)) begin
        buf_d      = in_req;
        buf_full_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      issue_q    <= '0;
      sel_q      <= '0;
      s_valid    <= '0;
      m_ready    <= 1'b0;
      m_rdata    <= '0;
      m_error    <= 1'b0;
      overflow   <= 1'b0;
`ifdef ROUTER_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      issue_q    <= issue_d;
      sel_q      <= sel_d;
      s_valid    <= s_valid_d;
      m_ready    <= m_ready_d;
      m_rdata    <= m_rdata_d;
      m_error    <= m_error_d;
      overflow   <= overflow_d;
`ifdef ROUTER_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  // Shared slave payload straight from the issue register.
  assign s_instr = issue_q.instr;
  assign s_addr  = ADDR_W'(issue_q.addr);
  assign s_wdata = DATA_W'(issue_q.wdata);
  assign s_wstrb = STRB_W'(issue_q.wstrb);

endmodule
